// File: rtl/enc_pkg.sv
// Shared widths, codes and types for the one-hot to binary encoder.
package enc_pkg;

    localparam int unsigned ONEHOT_W = 15;
    localparam int unsigned BIN_W    = 4;
    localparam logic [BIN_W-1:0] CODE_NONE = 4'hF;

    typedef logic [BIN_W-1:0] bin_t;

    // One buffered word: encoded index plus its not-one-hot flag.
    typedef struct packed {
        bin_t idx;
        logic err;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot encoder: lowest set bit index, flags multi-hot words.
module onehot_check
    import enc_pkg::*;
(
    input  logic [ONEHOT_W-1:0] in_i,
    output bin_t                idx_o,
    output logic                err_o
);

    always_comb begin
        idx_o = CODE_NONE;
        // Scan downwards so the lowest set bit is the last to win.
        for (int i = ONEHOT_W - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = bin_t'(i);
            end
        end
        err_o = |(in_i & (in_i - 1'b1));
    end

endmodule

// File: rtl/enc_onehot2bin.sv
// Registered one-hot to binary encoder behind a 2-entry skid buffer.
// Error counter is built only when ENC_ONEHOT2BIN_ERRCNT_EN is defined.
module enc_onehot2bin
    import enc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [ONEHOT_W-1:0] in,
    output logic                in_ready,
    output logic                out_valid,
    output logic [BIN_W-1:0]    out,
    output logic                out_err,
    input  logic                out_ready,
    input  logic                err_clr,
    output logic [7:0]          err_count
);

    skid_state_t state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      skid_q, skid_d;
    entry_t      enc;
    logic        push, pop;

    onehot_check u_check (
        .in_i  (in),
        .idx_o (enc.idx),
        .err_o (enc.err)
    );

    assign in_ready  = !rst && (state_q != FULL);
    assign out_valid = !rst && (state_q != EMPTY);
    assign out       = head_q.idx;
    assign out_err   = head_q.err;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = enc;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = enc;
                end else if (push) begin
                    skid_d  = enc;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '{idx: CODE_NONE, err: 1'b0};
            skid_q  <= '{idx: CODE_NONE, err: 1'b0};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ENC_ONEHOT2BIN_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // Clear takes priority over a coincident error transfer.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 8'd0;
        end else if (push && enc.err && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = 8'd0;
`endif

endmodule
